// File: rtl/spike_aer_encoder.sv
// Spike-to-AER encoder: latches per-neuron spikes and serialises them lowest-index-first
// into a FWFT event FIFO. Define SPIKE_AER_TIMESTAMP_EN to tag each event with a timestep.
module spike_aer_encoder #(
  parameter int unsigned NUM_NEURONS = 16,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TS_W        = 8,
  localparam int unsigned ADDR_W     = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_NEURONS-1:0] spike_i,
  output logic                   ev_valid_o,
  input  logic                   ev_ready_i,
  output logic [ADDR_W-1:0]      ev_addr_o,
  output logic [CNT_W-1:0]       fifo_count_o,
  output logic                   coalesce_o,
  output logic                   busy_o
`ifdef SPIKE_AER_TIMESTAMP_EN
  ,
  input  logic                   tick_i,
  output logic [TS_W-1:0]        ev_ts_o
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
`ifdef SPIKE_AER_TIMESTAMP_EN
  localparam int unsigned TSF_W = TS_W;
`else
  localparam int unsigned TSF_W = 0 * TS_W;
`endif
  localparam int unsigned ENTRY_W = ADDR_W + TSF_W;

  logic [NUM_NEURONS-1:0] r_pending_p0;
  logic                   r_coalesce;
  logic [NUM_NEURONS-1:0] w_grant_vec;
  logic [ADDR_W-1:0]      w_grant_idx;
  logic                   w_any;
  logic                   w_can_accept;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_valid;

  logic [ENTRY_W-1:0]     r_mem_p1 [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wptr;
  logic [PTR_W-1:0]       r_rptr;
  logic [CNT_W-1:0]       r_count;
  logic [ENTRY_W-1:0]     w_wdata;
  logic [ENTRY_W-1:0]     w_head;

  // Stage p0: spike capture and lowest-index grant
  always_comb begin
    w_grant_idx = '0;
    for (int i = int'(NUM_NEURONS) - 1; i >= 0; i--) begin
      if (r_pending_p0[i]) w_grant_idx = ADDR_W'(i);
    end
  end

  assign w_any        = |r_pending_p0;
  assign w_valid      = (r_count != '0);
  assign w_pop        = w_valid & ev_ready_i;
  assign w_can_accept = (r_count < CNT_W'(FIFO_DEPTH)) | w_pop;
  assign w_push       = w_any & w_can_accept;
  assign w_grant_vec  = w_push ? (NUM_NEURONS'(1) << w_grant_idx) : '0;

  // A re-asserted spike on the granted bit is a fresh event, not a merge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pending_p0 <= '0;
      r_coalesce   <= 1'b0;
    end else begin
      r_pending_p0 <= (r_pending_p0 & ~w_grant_vec) | spike_i;
      if (|(spike_i & r_pending_p0 & ~w_grant_vec)) r_coalesce <= 1'b1;
    end
  end

`ifdef SPIKE_AER_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       r_ts <= '0;
    else if (tick_i) r_ts <= r_ts + TS_W'(1);
  end

  assign w_wdata = {r_ts, w_grant_idx};
  assign ev_ts_o = w_valid ? w_head[ENTRY_W-1:ADDR_W] : '0;
`else
  assign w_wdata = w_grant_idx;
`endif

  // Stage p1: event FIFO, first-word-fall-through
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem_p1[r_wptr] <= w_wdata;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is masked while empty so stale storage never reaches the outputs
  assign w_head       = r_mem_p1[r_rptr];
  assign ev_valid_o   = w_valid;
  assign ev_addr_o    = w_valid ? w_head[ADDR_W-1:0] : '0;
  assign fifo_count_o = r_count;
  assign coalesce_o   = r_coalesce;
  assign busy_o       = w_any | w_valid;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder: latency, ordering, backpressure, coalescing,
// full-FIFO pass-through, async reset and (with SPIKE_AER_TIMESTAMP_EN) timestamps.
module tb_spike_aer_encoder;
  localparam int NN = 16;
  localparam int FD = 8;
`ifdef SPIKE_AER_TIMESTAMP_EN
  localparam int TSW = 2;
`else
  localparam int TSW = 8;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] spike = '0;
  logic        ready = 1'b0;
  logic        valid;
  logic [3:0]  addr;
  logic [3:0]  cnt;
  logic        coal;
  logic        busy;
`ifdef SPIKE_AER_TIMESTAMP_EN
  logic           tick = 1'b0;
  logic [TSW-1:0] ts;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int exp_q[$];

  spike_aer_encoder #(.NUM_NEURONS(NN), .FIFO_DEPTH(FD), .TS_W(TSW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .spike_i      (spike),
    .ev_valid_o   (valid),
    .ev_ready_i   (ready),
    .ev_addr_o    (addr),
    .fifo_count_o (cnt),
    .coalesce_o   (coal),
    .busy_o       (busy)
`ifdef SPIKE_AER_TIMESTAMP_EN
    ,
    .tick_i       (tick),
    .ev_ts_o      (ts)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects one event per cycle in exp_q order, count pinned at FD for the first full_cycles
  task automatic drain(input string tag, input int full_cycles);
    for (int k = 0; k < exp_q.size(); k++) begin
      chk({tag, "_valid"}, 32'(valid), 32'd1);
      chk({tag, "_addr"}, 32'(addr), 32'(exp_q[k]));
      if (k < full_cycles) chk({tag, "_full"}, 32'(cnt), 32'(FD));
      step();
    end
    chk({tag, "_empty"}, 32'(valid), 32'd0);
  endtask

  initial begin
    repeat (2) step();
    rst = 1'b0;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_count", 32'(cnt), 32'd0);
    chk("rst_coal", 32'(coal), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();

    // Single spike: valid exactly in cycle 2
    ready = 1'b1;
    spike = 16'h0001;
    step();
    spike = '0;
    chk("lat_c1_valid", 32'(valid), 32'd0);
    chk("lat_c1_busy", 32'(busy), 32'd1);
    step();
    chk("lat_c2_valid", 32'(valid), 32'd1);
    chk("lat_c2_addr", 32'(addr), 32'd0);
    chk("lat_c2_count", 32'(cnt), 32'd1);
    step();
    chk("lat_c3_valid", 32'(valid), 32'd0);
    chk("lat_c3_busy", 32'(busy), 32'd0);

    // Sparse snapshot leaves in ascending order, one per cycle
    spike = 16'h8421;
    step();
    spike = '0;
    chk("sparse_c1_valid", 32'(valid), 32'd0);
    step();
    exp_q = '{0, 5, 10, 15};
    drain("sparse", 0);
    chk("sparse_coal", 32'(coal), 32'd0);

    // Backpressure: FIFO saturates at 8, rest wait in pending, nothing lost
    ready = 1'b0;
    spike = 16'hFFFF;
    step();
    spike = '0;
    repeat (10) step();
    chk("bp_count", 32'(cnt), 32'(FD));
    chk("bp_addr", 32'(addr), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    ready = 1'b1;
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    drain("bp", 8);
    chk("bp_busy_end", 32'(busy), 32'd0);
    chk("bp_coal", 32'(coal), 32'd0);

    // Bit 3 re-spikes while stuck behind a full FIFO: merged into one event
    ready = 1'b0;
    spike = 16'h00FF;
    step();
    spike = '0;
    repeat (9) step();
    chk("co_count", 32'(cnt), 32'(FD));
    spike = 16'h0008;
    step();
    chk("co_pre_coal", 32'(coal), 32'd0);
    spike = 16'h0008;
    step();
    spike = '0;
    chk("co_coal", 32'(coal), 32'd1);
    chk("co_busy", 32'(busy), 32'd1);
    ready = 1'b1;
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 3};
    drain("co", 0);
    chk("co_coal_sticky", 32'(coal), 32'd1);

    // Full FIFO with pop+grant for 10 cycles; late low indices overtake 9..15
    ready = 1'b0;
    spike = 16'hFFFF;
    step();
    spike = '0;
    repeat (10) step();
    ready = 1'b1;
    spike = 16'h0003;
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 0, 1, 9, 10, 11, 12, 13, 14, 15};
    chk("wrap_first_addr", 32'(addr), 32'd0);
    step();
    spike = '0;
    exp_q.delete(0);
    chk("wrap_c1_count", 32'(cnt), 32'(FD));
    drain("wrap", 10);
    chk("wrap_busy_end", 32'(busy), 32'd0);

    // Async reset mid-burst clears everything without a clock edge
    ready = 1'b0;
    spike = 16'hFFFF;
    step();
    spike = '0;
    repeat (3) step();
    chk("ar_pre_count", 32'(cnt), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(valid), 32'd0);
    chk("ar_addr", 32'(addr), 32'd0);
    chk("ar_count", 32'(cnt), 32'd0);
    chk("ar_coal", 32'(coal), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b0;
    ready = 1'b1;
    repeat (3) step();
    chk("ar_post_busy", 32'(busy), 32'd0);
    chk("ar_post_valid", 32'(valid), 32'd0);

`ifdef SPIKE_AER_TIMESTAMP_EN
    // Five ticks on a 2-bit counter wrap to 1
    tick = 1'b1;
    repeat (5) step();
    tick = 1'b0;
    spike = 16'h0004;
    step();
    spike = '0;
    step();
    chk("ts_valid", 32'(valid), 32'd1);
    chk("ts_addr", 32'(addr), 32'd2);
    chk("ts_value", 32'(ts), 32'd1);
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/spike_aer_encoder.md
Name: spike_aer_encoder

Overview:
- Sits directly downstream of a layer of neurons and consumes their per-neuron spike outputs.
- Latches each spike and serialises spikes lowest-index-first into address-event (AER) words.
- Buffers events in a FIFO and presents them on a valid/ready stream to the router or axon fan-out stage.
- Converts a parallel, bursty spike vector into a rate-limited one-event-per-cycle stream.

Parameters:
- NUM_NEURONS, 16: width of spike input vector; must be >= 2.
- FIFO_DEPTH, 8: event FIFO entries; power of two, >= 2.
- TS_W, 8: timestamp width; used only with the optional feature.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- spike_i  in  NUM_NEURONS  one bit per neuron spike output; sampled every cycle.
- ev_valid_o  out  1  event available.
- ev_ready_i  in  1  consumer accepts the event when high together with ev_valid_o.
- ev_addr_o  out  ADDR_W  neuron index of the head event; ADDR_W = max(1, $clog2(NUM_NEURONS)).
- fifo_count_o  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- coalesce_o  out  1  sticky flag: a spike was merged into a still-pending spike of the same neuron.
- busy_o  out  1  high when any pending bit is set or the FIFO is non-empty.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - pending_r = 0; FIFO empty with pointers = 0.
  - ev_valid_o = 0, ev_addr_o = 0, fifo_count_o = 0, coalesce_o = 0, busy_o = 0.
  - Reset mid-operation discards all pending spikes and buffered events.
- Pending register, per edge: pending_r <= (pending_r & ~grant) | spike_i.
  - A spike on a bit that is pending and not granted this cycle sets coalesce_o.
  - coalesce_o stays set until reset.
- Grant:
  - The lowest-index set bit of pending_r is granted when the FIFO can accept.
  - FIFO can accept when count < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - At most one grant per cycle; grant = 0 when pending_r = 0.
- Granted bit:
  - Cleared in pending_r unless spike_i re-asserts it in the same cycle; in that case the bit stays set with no coalesce.
  - Its index is written to the FIFO tail on the same edge.
- FIFO: first-word-fall-through.
  - ev_valid_o = (count != 0); ev_addr_o = head entry.
  - Pop on ev_valid_o & ev_ready_i.
  - Push and pop in the same cycle: count unchanged, including when full.
  - Pointers wrap modulo FIFO_DEPTH.
  - ev_addr_o is held stable while ev_valid_o & !ev_ready_i.
- Latency: spike_i high in cycle 0 with empty pending and an uncongested FIFO gives ev_valid_o high in cycle 2.
- Throughput: one event per cycle sustained when ev_ready_i = 1.
- Full FIFO with ev_ready_i = 0: grants stall; spikes accumulate in pending_r; no event is ever dropped, only coalesced.
- Ordering: events from the same pending snapshot leave in ascending index order. A later-arriving lower index may overtake earlier higher indices that are still pending.
- busy_o = |pending_r | (count != 0), combinational from registers.

Optional Feature:
- Macro: SPIKE_AER_TIMESTAMP_EN.
- Defined:
  - Adds input tick_i (1) and output ev_ts_o (TS_W).
  - A free-running TS_W-bit timestep counter (reset 0) increments on each tick_i and wraps from 2^TS_W-1 to 0.
  - Each FIFO entry stores {counter value at the grant edge, addr}; ev_ts_o shows the head timestamp; FIFO width grows by TS_W.
- Not defined: the ports, counter and storage are absent; behaviour is otherwise identical.

Test Plan:
- Reset then spike_i = 16'h0001 for one cycle, ev_ready_i = 1 -> ev_valid_o high in cycle 2 only, ev_addr_o = 0, busy_o low after the pop.
- spike_i = 16'h8421 for one cycle, ev_ready_i = 1 -> four consecutive events with addr 0, 5, 10, 15; coalesce_o stays 0.
- ev_ready_i = 0 with spike_i = 16'hFFFF for one cycle -> fifo_count_o saturates at 8 (addr 0..7); pending holds 8..15. Then ev_ready_i = 1 -> 16 events 0..15 in order, no loss.
- Bit 3 pending behind a full FIFO while spike_i[3] pulses again -> coalesce_o = 1 and exactly one event with addr 3.
- Full FIFO with simultaneous pop and grant for 10 cycles -> fifo_count_o stays 8 and pointer wrap is correct. Async rst_i mid-burst -> all outputs 0 immediately.
- With SPIKE_AER_TIMESTAMP_EN, TS_W = 2: 5 tick_i pulses then spike_i[2] -> ev_ts_o = 1 (wrapped), ev_addr_o = 2.
